serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_if.sv | 34 +++
 rtl/serial_adder_digit_adder.sv | 34 +++
 rtl/serial_adder.sv | 94 +++++++++
 tb/tb_serial_adder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial_adder slice.
//   state_t    : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   clog2_min1 : ceil(log2(n)) clamped to at least 1, for counter widths
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w++;
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
//   in_valid/in_ready   : operand handshake (a, b, cin[, sub])
//   out_valid/out_ready : result handshake (sum, cout)
// master = producer/consumer side, slave = the adder.
// Optional SERIAL_ADDER_SUB_EN adds the 1-bit sub select.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: purely combinational DIGIT-bit ripple-carry adder.
//   x, y : digit operands
//   ci   : carry into bit 0
//   s    : digit sum
//   co   : carry out of the top bit
// Each stage is a full adder built from two half-adder cells and an OR.
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic h1_s, h1_c, h2_c;
        // first half adder: x + y
        assign h1_s = x[i] ^ y[i];
        assign h1_c = x[i] & y[i];
        // second half adder: partial sum + incoming carry
        assign s[i] = h1_s ^ c[i];
        assign h2_c = h1_s & c[i];
        assign c[i+1] = h1_c | h2_c;
    end

    assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder, DIGIT bits per clock over WIDTH-bit
// operands, carry held in a register between digits.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_adder_if.slave (operand and result handshakes)
// Optional macro SERIAL_ADDER_SUB_EN: bus.sub=1 computes a-b (cout=1 => no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int unsigned      NDIG = WIDTH / DIGIT;
    localparam int unsigned      CW   = clog2_min1(NDIG);
    localparam logic [CW-1:0]    LAST = CW'(NDIG - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic             carry_r, cout_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             dco;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x  (a_sh[DIGIT-1:0]),
        .y  (b_sh[DIGIT-1:0]),
        .ci (carry_r),
        .s  (dsum),
        .co (dco)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (cnt == LAST)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_sh <= bus.a;
                    cnt  <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                    // two's-complement subtract: a + ~b + 1
                    b_sh    <= bus.sub ? ~bus.b : bus.b;
                    carry_r <= bus.sub ? 1'b1   : bus.cin;
`else
                    b_sh    <= bus.b;
                    carry_r <= bus.cin;
`endif
                end
                RUN: begin
                    a_sh    <= a_sh >> DIGIT;
                    b_sh    <= b_sh >> DIGIT;
                    // new digit enters at the MSB end; after NDIG digits
                    // the first digit has reached bit 0
                    sum_r   <= (sum_r >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                    carry_r <= dco;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) cout_r <= dco;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (DIGIT=1,4,8, WIDTH=8).
// Driver pushes expected {sum, cout, latency} on acceptance; a negedge
// monitor pops/compares whenever out_valid is presented.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        int         lat;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t q0[$], q1[$], q2[$];
    bit   seen[3];
    bit   idle_chk[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(8)) if1 ();
    serial_adder_if #(.WIDTH(8)) if4 ();
    serial_adder_if #(.WIDTH(8)) if8 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int w);
        case (w)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int w, input exp_t e);
        case (w)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic exp_t qfront(input int w);
        case (w)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpop(input int w);
        case (w)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    function automatic logic rdy(input int w);
        case (w)
            0: return if1.in_ready;
            1: return if4.in_ready;
            default: return if8.in_ready;
        endcase
    endfunction

    task automatic set_in(input int w, input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic sb);
        case (w)
            0: begin
                if1.in_valid = v; if1.a = a; if1.b = b; if1.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
                if1.sub = sb;
`endif
            end
            1: begin
                if4.in_valid = v; if4.a = a; if4.b = b; if4.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
                if4.sub = sb;
`endif
            end
            default: begin
                if8.in_valid = v; if8.a = a; if8.b = b; if8.cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
                if8.sub = sb;
`endif
            end
        endcase
    endtask

    // monitor step for one instance
    task automatic mon_step(input int w, input logic ov, input logic ordy, input logic ir,
                            input logic [7:0] s, input logic c);
        exp_t e;
        if (rst) begin
            seen[w] = 1'b0;
            idle_chk[w] = 1'b0;
            return;
        end
        if (idle_chk[w]) begin
            chk($sformatf("in_ready_after_result[%0d]", w), 32'(ir), 32'd1);
            idle_chk[w] = 1'b0;
        end
        if (ov) begin
            if (qsize(w) == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid[%0d]: got out_valid=1 expected no result (sum=0x%0h)", w, s);
            end else begin
                e = qfront(w);
                if (!seen[w]) begin
                    chk($sformatf("latency[%0d]", w), 32'(cyc - e.acc), 32'(e.lat));
                    seen[w] = 1'b1;
                end
                chk($sformatf("sum[%0d]", w), 32'(s), 32'(e.sum));
                chk($sformatf("cout[%0d]", w), 32'(c), 32'(e.cout));
                chk($sformatf("in_ready_in_done[%0d]", w), 32'(ir), 32'd0);
                if (ordy) begin
                    qpop(w);
                    seen[w] = 1'b0;
                    idle_chk[w] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, if1.out_valid, if1.out_ready, if1.in_ready, if1.sum, if1.cout);
        mon_step(1, if4.out_valid, if4.out_ready, if4.in_ready, if4.sum, if4.cout);
        mon_step(2, if8.out_valid, if8.out_ready, if8.in_ready, if8.sum, if8.cout);
    end

    task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic sb, input bit push, input logic [7:0] es, input logic ec,
                         input int el);
        exp_t e;
        int   g;
        @(negedge clk);
        g = 0;
        while (!rdy(w) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout[%0d]: got in_ready=0 for 100 cycles expected 1", w);
            return;
        end
        set_in(w, 1'b1, a, b, ci, sb);
        @(posedge clk);
        #1;
        set_in(w, 1'b0, a, b, ci, sb);
        if (push) begin
            e.sum = es; e.cout = ec; e.lat = el; e.acc = cyc;
            qpush(w, e);
        end
    endtask

    task automatic wait_done(input int w);
        int g;
        g = 0;
        while (qsize(w) != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL result_timeout[%0d]: got %0d pending results expected 0", w, qsize(w));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        if1.out_ready = 1'b1;
        if4.out_ready = 1'b1;
        if8.out_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready1",  32'(if1.in_ready),  32'd1);
        chk("rst_out_valid1", 32'(if1.out_valid), 32'd0);
        chk("rst_sum1",       32'(if1.sum),       32'd0);
        chk("rst_cout1",      32'(if1.cout),      32'd0);
        chk("rst_in_ready4",  32'(if4.in_ready),  32'd1);
        chk("rst_out_valid8", 32'(if8.out_valid), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // DIGIT=1 basic ops
        issue(0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 8);
        wait_done(0);
        issue(0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8);
        wait_done(0);
        issue(0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8);
        wait_done(0);

        // DIGIT=4 and DIGIT=8
        issue(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 2);
        wait_done(1);
        issue(1, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 2);
        wait_done(1);
        issue(2, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1);
        wait_done(2);
        issue(2, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1);
        wait_done(2);

        // backpressure with ignored in_valid pulses
        @(posedge clk);
        #2 if1.out_ready = 1'b0;
        issue(0, 8'h37, 8'h48, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 8);
        g = 0;
        while (!if1.out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            #2 set_in(0, i[0] ? 1'b0 : 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        end
        @(posedge clk);
        #2;
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        if1.out_ready = 1'b1;
        wait_done(0);

        // reset mid-RUN, at digit 3
        issue(0, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(if1.out_valid), 32'd0);
        chk("abort_sum",       32'(if1.sum),       32'd0);
        chk("abort_cout",      32'(if1.cout),      32'd0);
        chk("abort_in_ready",  32'(if1.in_ready),  32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        issue(0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 8);
        wait_done(0);

`ifdef SERIAL_ADDER_SUB_EN
        issue(0, 8'h10, 8'h01, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b1, 8);
        wait_done(0);
        issue(0, 8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8);
        wait_done(0);
        issue(0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 8);
        wait_done(0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
